// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits, 3-sample majority vote per bit.
// Defining UART_RX_SYNC_EN puts RX_IN through a two-flop synchroniser, which adds 2 cycles to every response.
module uart_rx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] PRE_MIN   = PRESCALE_W'(4);
  localparam logic [3:0]            LAST_DATA = 4'(DATA_WIDTH - 1);

  logic rx;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], RX_IN};
  end
  assign rx = sync_q[1];
`else
  assign rx = RX_IN;
`endif

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  par_acc_q, par_acc_d, stp_acc_q, stp_acc_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

  logic [PRESCALE_W-1:0] mid;
  logic                  vote, vote_pt, bit_end, stp_now, last_stop;

  assign mid       = pre_q >> 1;
  assign vote      = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
  assign vote_pt   = (edge_q == mid + ONE);
  assign bit_end   = (edge_q == pre_q - ONE);
  assign stp_now   = stp_acc_q | ~vote;
  assign last_stop = (bit_q == {3'b000, stop2_q});

  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    pre_d     = pre_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    par_acc_d = par_acc_q;
    stp_acc_d = stp_acc_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    if (state_q != IDLE) begin
      edge_d = bit_end ? '0 : edge_q + ONE;
      if (edge_q == mid - ONE) s0_d = rx;
      if (edge_q == mid)       s1_d = rx;
    end

    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d   = START;
          edge_d    = '0;
          bit_d     = '0;
          pre_d     = (prescale < PRE_MIN) ? PRE_MIN : prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          stop2_d   = STOP2;
          par_acc_d = 1'b0;
          stp_acc_d = 1'b0;
        end
      end
      START: begin
        // A start bit that votes high was line noise, not a frame.
        if (vote_pt && vote) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (vote_pt) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (vote_pt) par_acc_d = vote ^ (^shift_q) ^ par_typ_q;
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (vote_pt) stp_acc_d = stp_now;
        // Resolve at the final vote so the rest of the stop bit can overlap the next start edge.
        if (vote_pt && last_stop) begin
          state_d = IDLE;
          edge_d  = '0;
          if (!par_acc_q && !stp_now) begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end else begin
            pe_d = par_acc_q;
            se_d = stp_now;
          end
        end else if (bit_end) begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      pre_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      pdata_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      par_acc_q <= 1'b0;
      stp_acc_q <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      pre_q     <= pre_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      par_acc_q <= par_acc_d;
      stp_acc_q <= stp_acc_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8-bit and 5-bit instances, expected result pulses queued per frame and matched as they appear.
module tb_uart_rx_param;
  localparam int PW = 6;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [8:0] dat;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx8 = 1'b1;
  logic          rx5 = 1'b1;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          stop2 = 1'b0;
  logic [PW-1:0] prescale = 6'd8;
  logic [7:0]    pdata8;
  logic          dv8, pe8, se8;
  logic [4:0]    pdata5;
  logic          dv5, pe5, se5;

  ev_t q8[$];
  ev_t q5[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  bit_cycles = 8;
  logic [8:0] last8 = 9'h000;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut8 (
    .clk(clk), .rst(rst), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .prescale(prescale), .P_DATA(pdata8), .data_valid(dv8), .par_err(pe8), .stp_err(se8));

  uart_rx_param #(.DATA_WIDTH(5), .PRESCALE_W(PW)) dut5 (
    .clk(clk), .rst(rst), .RX_IN(rx5), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .prescale(prescale), .P_DATA(pdata5), .data_valid(dv5), .par_err(pe5), .stp_err(se5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic par_of(input logic [8:0] d, input int n);
    logic p = 1'b0;
    for (int i = 0; i < n; i++) p ^= d[i];
    return p;
  endfunction

  task automatic expect_ev(input bit is5, input logic dv, input logic pe, input logic se, input logic [8:0] d);
    ev_t e;
    e.dv = dv; e.pe = pe; e.se = se; e.dat = d;
    if (is5) q5.push_back(e);
    else     q8.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst && (dv8 || pe8 || se8)) begin
      if (q8.size() == 0) check("dut8_unexpected_pulse", 32'({dv8, pe8, se8}), 32'd0);
      else begin
        e = q8.pop_front();
        check("dut8_flags", 32'({dv8, pe8, se8}), 32'({e.dv, e.pe, e.se}));
        check("dut8_pdata", 32'(pdata8), 32'(e.dat));
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst && (dv5 || pe5 || se5)) begin
      if (q5.size() == 0) check("dut5_unexpected_pulse", 32'({dv5, pe5, se5}), 32'd0);
      else begin
        e = q5.pop_front();
        check("dut5_flags", 32'({dv5, pe5, se5}), 32'({e.dv, e.pe, e.se}));
        check("dut5_pdata", 32'(pdata5), 32'(e.dat));
      end
    end
  end

  // Each bit is driven from a falling edge; a glitch flips the cycle seen by the middle vote sample.
  task automatic send_bit(input bit is5, input logic b, input bit glitch);
    logic v;
    for (int i = 0; i < bit_cycles; i++) begin
      v = (glitch && i == bit_cycles / 2 + 1) ? ~b : b;
      if (is5) rx5 = v;
      else     rx8 = v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input bit is5, input int nbits, input logic [8:0] d, input bit pen,
                            input logic pbit, input int nstop, input logic [1:0] sbits, input int gbit);
    send_bit(is5, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(is5, d[i], i == gbit);
    if (pen) send_bit(is5, pbit, 1'b0);
    for (int i = 0; i < nstop; i++) send_bit(is5, sbits[i], 1'b0);
  endtask

  task automatic idle(input bit is5, input int nb);
    for (int i = 0; i < nb; i++) send_bit(is5, 1'b1, 1'b0);
  endtask

  task automatic drain(input string tag, input bit is5);
    int n = 0;
    while (((is5 ? q5.size() : q8.size()) != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(is5 ? q5.size() : q8.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs8", 32'({pdata8, dv8, pe8, se8}), 32'd0);
    check("reset_outputs5", 32'({pdata5, dv5, pe5, se5}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    expect_ev(0, 1, 0, 0, 9'h0A5); last8 = 9'h0A5;
    send_frame(0, 8, 9'h0A5, 1, par_of(9'h0A5, 8), 1, 2'b11, -1);
    idle(0, 2);
    drain("a5_good", 0);
    check("a5_pdata", 32'(pdata8), 32'h0A5);

    expect_ev(0, 0, 1, 0, last8);
    send_frame(0, 8, 9'h0A5, 1, ~par_of(9'h0A5, 8), 1, 2'b11, -1);
    idle(0, 2);
    drain("a5_bad_parity", 0);

    expect_ev(0, 0, 1, 0, last8);
    send_frame(0, 8, 9'h012, 1, ~par_of(9'h012, 8), 1, 2'b11, -1);
    idle(0, 2);
    drain("12_bad_parity", 0);
    check("pdata_held_on_par_err", 32'(pdata8), 32'h0A5);

    // Odd parity, with the configuration changed mid-frame: the latched settings must win.
    par_typ = 1'b1;
    fork
      begin
        repeat (24) @(negedge clk);
        par_typ = 1'b0; par_en = 1'b0; stop2 = 1'b1;
      end
    join_none
    expect_ev(0, 1, 0, 0, 9'h012); last8 = 9'h012;
    send_frame(0, 8, 9'h012, 1, ~par_of(9'h012, 8), 1, 2'b11, -1);
    idle(0, 3);
    drain("odd_parity_latched_cfg", 0);

    par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    expect_ev(0, 0, 1, 1, last8);
    send_frame(0, 8, 9'h00F, 1, ~par_of(9'h00F, 8), 1, 2'b00, -1);
    idle(0, 3);
    drain("par_and_stop_err", 0);

    par_en = 1'b0; stop2 = 1'b1;
    expect_ev(0, 0, 0, 1, last8);
    send_frame(0, 8, 9'h077, 0, 1'b0, 2, 2'b01, -1);
    idle(0, 3);
    drain("second_stop_low", 0);
    expect_ev(0, 1, 0, 0, 9'h03C); last8 = 9'h03C;
    send_frame(0, 8, 9'h03C, 0, 1'b0, 2, 2'b11, -1);
    idle(0, 2);
    drain("3c_after_stp_err", 0);

    stop2 = 1'b0;
    rx8 = 1'b0;
    repeat (2) @(negedge clk);
    rx8 = 1'b1;
    idle(0, 2);
    expect_ev(0, 1, 0, 0, 9'h081); last8 = 9'h081;
    send_frame(0, 8, 9'h081, 0, 1'b0, 1, 2'b11, -1);
    idle(0, 2);
    drain("81_after_start_glitch", 0);

    expect_ev(0, 1, 0, 0, 9'h0FF); last8 = 9'h0FF;
    send_frame(0, 8, 9'h0FF, 0, 1'b0, 1, 2'b11, 3);
    idle(0, 2);
    drain("ff_data_glitch", 0);
    check("ff_pdata", 32'(pdata8), 32'h0FF);

    // Prescale below the minimum behaves as 4 clocks per bit.
    prescale = 6'd2; bit_cycles = 4;
    expect_ev(0, 1, 0, 0, 9'h05A); last8 = 9'h05A;
    send_frame(0, 8, 9'h05A, 0, 1'b0, 1, 2'b11, -1);
    idle(0, 3);
    drain("prescale_clamped", 0);
    prescale = 6'd8; bit_cycles = 8;

    expect_ev(1, 1, 0, 0, 9'h015);
    expect_ev(1, 1, 0, 0, 9'h00A);
    send_frame(1, 5, 9'h015, 0, 1'b0, 1, 2'b11, -1);
    send_frame(1, 5, 9'h00A, 0, 1'b0, 1, 2'b11, -1);
    idle(1, 2);
    drain("w5_back_to_back", 1);
    check("w5_pdata", 32'(pdata5), 32'h00A);

    send_bit(1, 1'b0, 1'b0);
    send_bit(1, 1'b1, 1'b0);
    send_bit(1, 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("w5_reset_midframe", 32'({pdata5, dv5, pe5, se5}), 32'd0);
    check("w8_reset_midframe", 32'(pdata8), 32'd0);
    rx5 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(1, 3);
    check("w5_no_pulse_after_reset", 32'(pdata5), 32'd0);
    expect_ev(1, 1, 0, 0, 9'h00B);
    send_frame(1, 5, 9'h00B, 0, 1'b0, 1, 2'b11, -1);
    idle(1, 2);
    drain("w5_recover", 1);

    check("q8_empty", 32'(q8.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
